// File: rtl/i2c_controller.sv
// i2c_controller: single-master I2C engine for one-byte read or write frames.
// A free-running divider produces i2c_clk. Its rising and falling edges are
// one-cycle enables in the clk domain. The FSM advances on the rising
// enables. SDA and the SCL gate are updated on the falling enables, so data
// only moves while SCL is low.
`timescale 1ns/100ps
module i2c_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       ready,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl
);

  localparam int HALF = CLK_DIV / 2;
  localparam int DIVW = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_START      = 4'd1,
    ST_ADDRESS    = 4'd2,
    ST_READ_ACK   = 4'd3,
    ST_WRITE_DATA = 4'd4,
    ST_READ_ACK2  = 4'd5,
    ST_READ_DATA  = 4'd6,
    ST_WRITE_ACK  = 4'd7,
    ST_STOP       = 4'd8
  } state_e;

  logic [DIVW-1:0] div_q;
  logic            i2c_clk_q;
  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [7:0]      saved_addr_q, saved_addr_d;
  logic [7:0]      saved_data_q, saved_data_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            sda_out_q, sda_out_d;
  logic            sda_oe_q, sda_oe_d;
  logic            scl_en_q, scl_en_d;

  logic tick_s, rise_s, fall_s, scl_s, sda_in_s, accept_s;

  assign tick_s   = (div_q == DIVW'(HALF - 1));
  assign rise_s   = tick_s & ~i2c_clk_q;
  assign fall_s   = tick_s & i2c_clk_q;
  assign scl_s    = scl_en_q ? i2c_clk_q : 1'b1;
  assign sda_in_s = i2c_sda;

  // SCL is push-pull; SDA is either driven or released for the slave
  assign i2c_scl = scl_s;
  assign i2c_sda = sda_oe_q ? sda_out_q : 1'bz;

  // Ready only when the bus is fully idle (both lines high) and nothing is queued
  assign ready = (state_q == ST_IDLE) & sda_oe_q & sda_out_q & scl_s & ~pending_q & ~rst;
  assign accept_s = ready & enable;
  assign data_out = data_out_q;

  // Free-running divider: toggles i2c_clk every HALF clk cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= {DIVW{1'b0}};
      i2c_clk_q <= 1'b0;
    end else if (tick_s) begin
      div_q     <= {DIVW{1'b0}};
      i2c_clk_q <= ~i2c_clk_q;
    end else begin
      div_q     <= div_q + DIVW'(1);
    end
  end

  // Frame state, bit counter, request capture and line drive registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      pending_q    <= 1'b0;
      saved_addr_q <= 8'd0;
      saved_data_q <= 8'd0;
      data_out_q   <= 8'd0;
      sda_out_q    <= 1'b1;
      sda_oe_q     <= 1'b1;
      scl_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      saved_addr_q <= saved_addr_d;
      saved_data_q <= saved_data_d;
      data_out_q   <= data_out_d;
      sda_out_q    <= sda_out_d;
      sda_oe_q     <= sda_oe_d;
      scl_en_q     <= scl_en_d;
    end
  end

  // Next-state: capture on accept, advance on rising i2c_clk, drive lines on falling
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    saved_addr_d = saved_addr_q;
    saved_data_d = saved_data_q;
    data_out_d   = data_out_q;
    sda_out_d    = sda_out_q;
    sda_oe_d     = sda_oe_q;
    scl_en_d     = scl_en_q;

    if (accept_s) begin
      saved_addr_d = {addr, rw};
      saved_data_d = data_in;
      pending_d    = 1'b1;
    end else begin
      pending_d    = pending_q;
    end

    if (rise_s) begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            state_d   = ST_START;
            pending_d = 1'b0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_START: begin
          cnt_d   = 3'd7;
          state_d = ST_ADDRESS;
        end
        ST_ADDRESS: begin
          if (cnt_q == 3'd0) state_d = ST_READ_ACK;
          else               cnt_d   = cnt_q - 3'd1;
        end
        ST_READ_ACK: begin
          // Anything but a driven low (high or floating) is a NACK
          if (sda_in_s == 1'b0) begin
            cnt_d   = 3'd7;
            state_d = saved_addr_q[0] ? ST_READ_DATA : ST_WRITE_DATA;
          end else begin
            state_d = ST_STOP;
          end
        end
        ST_WRITE_DATA: begin
          if (cnt_q == 3'd0) state_d = ST_READ_ACK2;
          else               cnt_d   = cnt_q - 3'd1;
        end
        ST_READ_ACK2: state_d = ST_STOP;
        ST_READ_DATA: begin
          data_out_d[cnt_q] = sda_in_s;
          if (cnt_q == 3'd0) state_d = ST_WRITE_ACK;
          else               cnt_d   = cnt_q - 3'd1;
        end
        ST_WRITE_ACK: state_d = ST_STOP;
        ST_STOP:      state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    if (fall_s) begin
      scl_en_d = (state_q != ST_IDLE) && (state_q != ST_START);
      case (state_q)
        ST_IDLE:       begin sda_oe_d = 1'b1; sda_out_d = 1'b1;                      end
        ST_START:      begin sda_oe_d = 1'b1; sda_out_d = 1'b0;                      end
        ST_ADDRESS:    begin sda_oe_d = 1'b1; sda_out_d = saved_addr_q[cnt_q];       end
        ST_WRITE_DATA: begin sda_oe_d = 1'b1; sda_out_d = saved_data_q[cnt_q];       end
        ST_WRITE_ACK:  begin sda_oe_d = 1'b1; sda_out_d = 1'b1;                      end
        ST_STOP:       begin sda_oe_d = 1'b1; sda_out_d = 1'b0;                      end
        ST_READ_ACK, ST_READ_ACK2, ST_READ_DATA: begin
          sda_oe_d  = 1'b0;
          sda_out_d = 1'b1;
        end
        default:       begin sda_oe_d = 1'b1; sda_out_d = 1'b1;                      end
      endcase
    end else begin
      scl_en_d = scl_en_q;
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: directed table plus random frames against a behavioural
// I2C slave. The expected results come from simple frame arithmetic.
`timescale 1ns/100ps
module tb_i2c_controller;
  localparam int         CLK_DIV = 4;
  localparam logic [6:0] SL_ADDR = 7'h2A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] addr = 7'd0;
  logic [7:0] data_in = 8'd0;
  logic       enable = 1'b0;
  logic       rw = 1'b0;
  wire  [7:0] data_out;
  wire        ready;
  wire        i2c_sda;
  wire        i2c_scl;

  logic sl_low = 1'b0;
  pullup (i2c_sda);
  assign i2c_sda = sl_low ? 1'b0 : 1'bz;

  always #1 clk = ~clk;

  i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .enable(enable),
    .rw(rw), .data_out(data_out), .ready(ready), .i2c_sda(i2c_sda), .i2c_scl(i2c_scl)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [7:0] model_dout = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural slave at SL_ADDR (samples at negedge clk) ----
  logic       psda = 1'b1, pscl = 1'b1;
  int         phase = 0, cnt = 0;
  logic [7:0] sh = 8'd0, sl_tx = 8'd0, sl_addr_byte = 8'd0, sl_rx = 8'd0;
  logic       sl_rw = 1'b0, sl_mack = 1'b0;
  int         sl_rx_cnt = 0, sl_stops = 0, sl_start_cyc = 0, sl_rises = 0;

  // Slave: detects START/STOP, shifts bits on SCL rise, drives SDA on SCL fall
  always @(negedge clk) begin
    psda <= i2c_sda;
    pscl <= i2c_scl;
    if (rst) begin
      phase  <= 0;
      sl_low <= 1'b0;
    end else if (pscl && i2c_scl && psda && !i2c_sda) begin
      phase <= 1; cnt <= 0; sl_low <= 1'b0;
      sl_start_cyc <= cyc; sl_rises <= 0; sl_mack <= 1'b0;
    end else if (pscl && i2c_scl && !psda && i2c_sda) begin
      phase <= 0; sl_low <= 1'b0; sl_stops <= sl_stops + 1;
    end else if (!pscl && i2c_scl) begin
      sl_rises <= sl_rises + 1;
      case (phase)
        1: begin
          sh <= {sh[6:0], i2c_sda}; cnt <= cnt + 1;
          if (cnt == 7) begin
            sl_addr_byte <= {sh[6:0], i2c_sda};
            sl_rw        <= i2c_sda;
            phase        <= (sh[6:0] == SL_ADDR) ? 2 : 0;
          end
        end
        3: begin
          sh <= {sh[6:0], i2c_sda}; cnt <= cnt + 1;
          if (cnt == 7) begin
            sl_rx <= {sh[6:0], i2c_sda}; sl_rx_cnt <= sl_rx_cnt + 1; phase <= 4;
          end
        end
        5: begin
          cnt <= cnt + 1;
          if (cnt == 7) phase <= 6;
        end
        7: begin sl_mack <= i2c_sda; phase <= 0; end
        default: ;
      endcase
    end else if (pscl && !i2c_scl) begin
      case (phase)
        2:  begin sl_low <= 1'b1; phase <= 21; end
        21: begin
          cnt <= 0;
          if (sl_rw) begin sl_low <= ~sl_tx[7]; phase <= 5; end
          else       begin sl_low <= 1'b0;      phase <= 3; end
        end
        5:  sl_low <= ~sl_tx[7 - cnt];
        6:  begin sl_low <= 1'b0; phase <= 7; end
        4:  begin sl_low <= 1'b1; phase <= 41; end
        41: begin sl_low <= 1'b0; phase <= 0; end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One complete request; expectations come from the ACK outcome and frame arithmetic
  task automatic do_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                        input logic [7:0] tx, input bit pulse, input bit poke,
                        input logic exp_ack, input logic [7:0] exp_dout);
    int n;
    int stops0, rx0, len;
    bit done;
    sl_tx  = tx;
    n = 0;
    while (!ready && n < 300) begin @(negedge clk); n++; end
    chk("ready_before_req", {31'd0, ready}, 32'd1);
    stops0 = sl_stops; rx0 = sl_rx_cnt;
    @(posedge clk); #0.5;
    addr = a; rw = r; data_in = d; enable = 1'b1;
    if (pulse) begin
      @(posedge clk); #0.5;
    end else begin
      repeat (5) @(posedge clk);
      #0.5;
    end
    enable = 1'b0;
    if (poke) begin
      addr = a ^ 7'h55; rw = ~r; data_in = ~d; enable = 1'b1;
      repeat (10) @(posedge clk);
      #0.5;
      enable = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready) begin done = 1'b1; break; end
    end
    len = cyc - sl_start_cyc;
    chk("frame_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("addr_byte", {24'd0, sl_addr_byte}, {24'd0, a, r});
    chk("scl_rises", sl_rises, exp_ack ? 32'd19 : 32'd10);
    chk("start_to_ready", len, exp_ack ? 32'(20 * CLK_DIV) : 32'(11 * CLK_DIV));
    chk("stop_seen", sl_stops, stops0 + 1);
    chk("data_out", {24'd0, data_out}, {24'd0, exp_dout});
    if (!r && exp_ack) begin
      chk("slave_rx_cnt", sl_rx_cnt, rx0 + 1);
      chk("slave_rx", {24'd0, sl_rx}, {24'd0, d});
    end else begin
      chk("no_data_rx", sl_rx_cnt, rx0);
    end
    if (r && exp_ack) chk("master_nack", {31'd0, sl_mack}, 32'd1);
  endtask

  typedef struct {
    logic [6:0] a;
    logic       r;
    logic [7:0] d;
    logic [7:0] tx;
    bit         pulse;
    bit         poke;
    logic       exp_ack;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    logic [6:0] ra;
    logic       rr, rack;
    logic [7:0] rd, rtx;
    bit         rp;

    vecs[0] = '{a:7'h2A, r:1'b0, d:8'hAA, tx:8'h00, pulse:1'b0, poke:1'b0, exp_ack:1'b1, exp_dout:8'h00};
    vecs[1] = '{a:7'h2A, r:1'b1, d:8'h00, tx:8'hCC, pulse:1'b0, poke:1'b0, exp_ack:1'b1, exp_dout:8'hCC};
    vecs[2] = '{a:7'h15, r:1'b1, d:8'h00, tx:8'h33, pulse:1'b0, poke:1'b0, exp_ack:1'b0, exp_dout:8'hCC};
    vecs[3] = '{a:7'h2A, r:1'b0, d:8'h3C, tx:8'h00, pulse:1'b1, poke:1'b1, exp_ack:1'b1, exp_dout:8'hCC};

    // reset state
    #99.5;
    chk("rst_scl", {31'd0, i2c_scl}, 32'd1);
    chk("rst_sda", {31'd0, i2c_sda}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    @(posedge clk); #0.5; rst = 1'b0;
    n = 0;
    while (!ready && n < 50) begin @(posedge clk); #0.5; n++; end
    chk("ready_after_rst", {31'd0, (n <= CLK_DIV)}, 32'd1);

    // directed table
    for (int i = 0; i < 4; i++) begin
      do_txn(vecs[i].a, vecs[i].r, vecs[i].d, vecs[i].tx, vecs[i].pulse, vecs[i].poke,
             vecs[i].exp_ack, vecs[i].exp_dout);
    end
    model_dout = 8'hCC;

    // random frames against the reference model
    for (int i = 0; i < 10; i++) begin
      ra   = ($urandom_range(0, 2) != 0) ? SL_ADDR : 7'($urandom);
      rr   = 1'($urandom);
      rd   = 8'($urandom);
      rtx  = 8'($urandom);
      rp   = 1'($urandom);
      rack = (ra == SL_ADDR);
      if (rr && rack) model_dout = rtx;
      do_txn(ra, rr, rd, rtx, rp, 1'b0, rack, model_dout);
    end

    // reset in the middle of the write data phase
    sl_tx = 8'h00;
    @(posedge clk); #0.5;
    addr = SL_ADDR; rw = 1'b0; data_in = 8'h5A; enable = 1'b1;
    @(posedge clk); #0.5;
    enable = 1'b0;
    n = 0;
    while (!(phase == 3 && cnt == 3) && n < 300) begin @(negedge clk); n++; end
    chk("reach_write_data", {31'd0, (n < 300)}, 32'd1);
    @(posedge clk); #0.5;
    rst = 1'b1;
    #0.2;
    chk("midrst_sda", {31'd0, i2c_sda}, 32'd1);
    chk("midrst_scl", {31'd0, i2c_scl}, 32'd1);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_data_out", {24'd0, data_out}, 32'd0);
    repeat (3) @(posedge clk);
    #0.5;
    rst = 1'b0;
    model_dout = 8'h00;
    n = 0;
    while (!ready && n < 50) begin @(posedge clk); #0.5; n++; end
    chk("ready_after_midrst", {31'd0, (n <= CLK_DIV)}, 32'd1);
    do_txn(SL_ADDR, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b1, model_dout);
    model_dout = 8'h96;
    do_txn(SL_ADDR, 1'b1, 8'h00, 8'h96, 1'b0, 1'b0, 1'b1, model_dout);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
